// File: rtl/secuencia_detector_param.sv
// -----------------------------------------------------------------------------
// secuencia_detector_param
//
// Parametrised serial pattern detector (Moore). Samples 'w' on edges where
// 'en' is high, keeps the last N bits in a shift register and raises a
// registered flag 'z' when they equal the target pattern. Detection can be
// overlapping or non-overlapping (OVERLAP). A saturating counter records how
// many matches have been seen; 'clr' zeroes only that counter.
//
// Optional build macro: SECUENCIA_PATTERN_LOAD_EN
//   Adds 'pat_load'/'pat_in' so the target pattern can be reloaded at run
//   time. A load edge clears the history and the flag and samples nothing.
// -----------------------------------------------------------------------------
module secuencia_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             CW      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   w,
    input  logic                   clr,
`ifdef SECUENCIA_PATTERN_LOAD_EN
    input  logic                   pat_load,
    input  logic [N-1:0]           pat_in,
`endif
    output logic                   z,
    output logic [CW-1:0]          count,
    output logic [$clog2(N+1)-1:0] fill
);

    localparam int             FW       = $clog2(N + 1);
    localparam logic [FW-1:0]  FILL_MAX = FW'(N);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    // Architectural state
    logic [N-1:0]  hist_q,  hist_d;
    logic [FW-1:0] fill_q,  fill_d;
    logic          z_q,     z_d;
    logic [CW-1:0] count_q, count_d;

    // Derived values for the current sampling edge
    logic [N-1:0]  next_hist;
    logic [FW-1:0] next_fill;
    logic [N-1:0]  pat_cur;
    logic          load;
    logic          match;

`ifdef SECUENCIA_PATTERN_LOAD_EN
    logic [N-1:0]  pat_q, pat_d;

    assign pat_cur = pat_q;
    assign load    = pat_load;
`else
    assign pat_cur = PATTERN;
    assign load    = 1'b0;
`endif

    // Candidate history/fill if this edge samples 'w', and the match decision.
    // A match needs a completely filled history, so a partial history right
    // after reset or a non-overlapping restart can never alias the pattern.
    always_comb begin
        next_hist = {hist_q[N-2:0], w};
        next_fill = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FW'(1);
        match     = en && !load && (next_fill == FILL_MAX) && (next_hist == pat_cur);
    end

    // Next-state logic: pattern load, sampling, and the match counter.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        hist_d  = hist_q;
        fill_d  = fill_q;
        z_d     = z_q;
        count_d = count_q;
`ifdef SECUENCIA_PATTERN_LOAD_EN
        pat_d   = pat_q;
`endif

        if (load) begin
            // Reload the target; old history is meaningless against it.
`ifdef SECUENCIA_PATTERN_LOAD_EN
            pat_d  = pat_in;
`endif
            hist_d = '0;
            fill_d = '0;
            z_d    = 1'b0;
        end else if (en) begin
            z_d    = match;
            hist_d = next_hist;
            // Non-overlapping mode restarts the history count after a hit;
            // the bits shifted into hist are then ignored until refilled.
            if (match && (OVERLAP == 0)) begin
                fill_d = '0;
            end else begin
                fill_d = next_fill;
            end
        end

        // Clear wins over the old value but a same-edge match still counts.
        if (clr) begin
            count_d = match ? CW'(1) : '0;
        end else if (match && (count_q != CNT_MAX)) begin
            count_d = count_q + CW'(1);
        end
    end

    // State register with synchronous, active-high reset (highest priority).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= 1'b0;
            count_q <= '0;
`ifdef SECUENCIA_PATTERN_LOAD_EN
            pat_q   <= PATTERN;
`endif
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            z_q     <= z_d;
            count_q <= count_d;
`ifdef SECUENCIA_PATTERN_LOAD_EN
            pat_q   <= pat_d;
`endif
        end
    end

    // Outputs come straight from registers (Moore).
    always_comb begin
        z     = z_q;
        count = count_q;
        fill  = fill_q;
    end

endmodule
